// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared frame type and buffer state encoding for the audio path.
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int C_SAMPLE_WIDTH = 16;

    typedef struct packed {
        logic signed [C_SAMPLE_WIDTH-1:0] left;
        logic signed [C_SAMPLE_WIDTH-1:0] right;
    } audio_frame_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } buffer_state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/audio_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : audio_fifo_ram
// Purpose  : Frame storage, one synchronous write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
module audio_fifo_ram
    import audio_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  inp_clock,
    input  logic                  inp_wr_en,
    input  logic [DEPTH_LOG2-1:0] inp_wr_addr,
    input  audio_frame_t          inp_wr_data,
    input  logic [DEPTH_LOG2-1:0] inp_rd_addr,
    output audio_frame_t          out_rd_data
);

    audio_frame_t r_mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge inp_clock) begin
        if (inp_wr_en) begin
            r_mem[inp_wr_addr] <= inp_wr_data;
        end
    end

    assign out_rd_data = r_mem[inp_rd_addr];

endmodule : audio_fifo_ram
`default_nettype wire

// File: rtl/audio_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_buffer
// Purpose  : Stereo frame FIFO feeding the serializer, with fill/run priming.
//            AUDIO_BUFFER_HOLD_LAST_EN: repeat last popped frame instead of
//            silence on FILL pulls and underruns.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_buffer
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = C_SAMPLE_WIDTH,
    parameter int DEPTH_LOG2   = 4,
    parameter int PRIME_LEVEL  = 4
) (
    input  logic                    inp_clock,
    input  logic                    inp_reset,
    input  logic [SAMPLE_WIDTH-1:0] inp_left,
    input  logic [SAMPLE_WIDTH-1:0] inp_right,
    input  logic                    inp_valid,
    output logic                    out_ready,
    input  logic                    inp_pull,
    output logic [SAMPLE_WIDTH-1:0] out_left,
    output logic [SAMPLE_WIDTH-1:0] out_right,
    output logic                    out_frame_valid,
    output logic [DEPTH_LOG2:0]     out_level,
    output logic                    out_underrun,
    input  logic                    inp_clear
);

    localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] C_PRIME = (DEPTH_LOG2+1)'(PRIME_LEVEL);

    buffer_state_t           r_state;
    buffer_state_t           w_state_next;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;
    audio_frame_t            r_out;
    logic                    r_frame_valid;
    logic                    r_underrun;
    audio_frame_t            w_wr_frame;
    audio_frame_t            w_rd_frame;
    audio_frame_t            w_silence;
    audio_frame_t            w_frame_sel;
    logic                    w_push;
    logic                    w_pull;
    logic                    w_pop;
    logic                    w_underrun;

    assign w_wr_frame = '{left: inp_left, right: inp_right};

    audio_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .inp_clock   (inp_clock),
        .inp_wr_en   (w_push),
        .inp_wr_addr (r_wr_ptr),
        .inp_wr_data (w_wr_frame),
        .inp_rd_addr (r_rd_ptr),
        .out_rd_data (w_rd_frame)
    );

`ifdef AUDIO_BUFFER_HOLD_LAST_EN
    audio_frame_t r_last;

    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_rd_frame;
        end
    end

    assign w_silence = r_last;
`else
    assign w_silence = '0;
`endif

    // State register
    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: priming is judged on the registered level
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (r_level >= C_PRIME) w_state_next = RUN;
            RUN:     if (w_underrun)         w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // State-dependent control; an empty RUN pull never bypasses a same-cycle push
    always_comb begin
        w_pull      = inp_pull && !inp_reset;
        w_push      = inp_valid && !inp_reset && (r_level != C_DEPTH);
        w_pop       = w_pull && (r_state == RUN) && (r_level != '0);
        w_underrun  = w_pull && (r_state == RUN) && (r_level == '0);
        w_frame_sel = w_pop ? w_rd_frame : w_silence;
    end

    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_out         <= '0;
            r_frame_valid <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_pull) r_out <= w_frame_sel;
            r_frame_valid <= w_pull;
            if (w_underrun) begin
                r_underrun <= 1'b1;
            end else if (inp_clear) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign out_ready       = !inp_reset && (r_level != C_DEPTH);
    assign out_left        = r_out.left;
    assign out_right       = r_out.right;
    assign out_frame_valid = r_frame_valid;
    assign out_level       = r_level;
    assign out_underrun    = r_underrun;

endmodule : audio_sample_buffer
`default_nettype wire

// File: tb/tb_audio_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_sample_buffer
// Purpose  : Directed vector table plus hand sequences for audio_sample_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sample_buffer;

    logic        inp_clock = 1'b0;
    logic        inp_reset = 1'b0;
    logic [15:0] inp_left  = '0;
    logic [15:0] inp_right = '0;
    logic        inp_valid = 1'b0;
    logic        inp_pull  = 1'b0;
    logic        inp_clear = 1'b0;
    logic        out_ready;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_frame_valid;
    logic [4:0]  out_level;
    logic        out_underrun;

    int checks = 0;
    int errors = 0;

`ifdef AUDIO_BUFFER_HOLD_LAST_EN
    localparam bit C_HOLD = 1'b1;
`else
    localparam bit C_HOLD = 1'b0;
`endif

    audio_sample_buffer #(
        .SAMPLE_WIDTH (16),
        .DEPTH_LOG2   (4),
        .PRIME_LEVEL  (4)
    ) dut (
        .inp_clock       (inp_clock),
        .inp_reset       (inp_reset),
        .inp_left        (inp_left),
        .inp_right       (inp_right),
        .inp_valid       (inp_valid),
        .out_ready       (out_ready),
        .inp_pull        (inp_pull),
        .out_left        (out_left),
        .out_right       (out_right),
        .out_frame_valid (out_frame_valid),
        .out_level       (out_level),
        .out_underrun    (out_underrun),
        .inp_clear       (inp_clear)
    );

    always #5 inp_clock = ~inp_clock;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [15:0] l;
        logic [15:0] r;
        logic        pull;
        logic        clear;
        logic        e_ready;
        logic [4:0]  e_level;
        logic        e_fv;
        logic [15:0] e_l;
        logic [15:0] e_r;
        logic        e_ur;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(logic rst, logic valid, logic [15:0] l, logic [15:0] r,
                                logic pull, logic clear, logic e_ready, logic [4:0] e_level,
                                logic e_fv, logic [15:0] e_l, logic [15:0] e_r, logic e_ur);
        vec_t v;
        v.rst = rst; v.valid = valid; v.l = l; v.r = r; v.pull = pull; v.clear = clear;
        v.e_ready = e_ready; v.e_level = e_level; v.e_fv = e_fv;
        v.e_l = e_l; v.e_r = e_r; v.e_ur = e_ur;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge inp_clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic valid, input logic [15:0] l,
                         input logic [15:0] r, input logic pull, input logic clear);
        inp_reset = rst; inp_valid = valid; inp_left = l; inp_right = r;
        inp_pull = pull; inp_clear = clear;
    endtask

    logic [15:0] q_l [$];
    logic [15:0] q_r [$];
    logic [15:0] el, er;
    logic [15:0] h14_l, h14_r, h25_l, h25_r, hc_l, hc_r;

    initial begin
        h14_l = C_HOLD ? 16'h0707 : 16'h0; h14_r = C_HOLD ? 16'h0808 : 16'h0;
        h25_l = C_HOLD ? 16'h1004 : 16'h0; h25_r = C_HOLD ? 16'h2004 : 16'h0;
        hc_l  = C_HOLD ? 16'h1234 : 16'h0; hc_r  = C_HOLD ? 16'h5678 : 16'h0;

        //            rst vld  left     right    pul clr rdy lvl fv  exp_l    exp_r    ur
        tbl[0]  = mk(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[2]  = mk(0, 1, 16'h0101, 16'h0202, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0);
        tbl[3]  = mk(0, 1, 16'h0303, 16'h0404, 0, 0, 1, 2, 0, 16'h0000, 16'h0000, 0);
        tbl[4]  = mk(0, 1, 16'h0505, 16'h0606, 0, 0, 1, 3, 0, 16'h0000, 16'h0000, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 3, 1, 16'h0000, 16'h0000, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 3, 0, 16'h0000, 16'h0000, 0);
        tbl[7]  = mk(0, 1, 16'h0707, 16'h0808, 0, 0, 1, 4, 0, 16'h0000, 16'h0000, 0);
        tbl[8]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 4, 0, 16'h0000, 16'h0000, 0);
        tbl[9]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 3, 1, 16'h0101, 16'h0202, 0);
        tbl[10] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 2, 1, 16'h0303, 16'h0404, 0);
        tbl[11] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, 16'h0505, 16'h0606, 0);
        tbl[12] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, 16'h0707, 16'h0808, 0);
        tbl[13] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0707, 16'h0808, 0);
        tbl[14] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, h14_l,    h14_r,    1);
        tbl[15] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, h14_l,    h14_r,    0);
        tbl[16] = mk(0, 1, 16'h1001, 16'h2001, 0, 0, 1, 1, 0, h14_l,    h14_r,    0);
        tbl[17] = mk(0, 1, 16'h1002, 16'h2002, 0, 0, 1, 2, 0, h14_l,    h14_r,    0);
        tbl[18] = mk(0, 1, 16'h1003, 16'h2003, 0, 0, 1, 3, 0, h14_l,    h14_r,    0);
        tbl[19] = mk(0, 1, 16'h1004, 16'h2004, 0, 0, 1, 4, 0, h14_l,    h14_r,    0);
        tbl[20] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 4, 0, h14_l,    h14_r,    0);
        tbl[21] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 3, 1, 16'h1001, 16'h2001, 0);
        tbl[22] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 2, 1, 16'h1002, 16'h2002, 0);
        tbl[23] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, 16'h1003, 16'h2003, 0);
        tbl[24] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 1, 16'h1004, 16'h2004, 0);
        tbl[25] = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 0, 1, h25_l,    h25_r,    1);
        tbl[26] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, h25_l,    h25_r,    0);

        #1;
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].l, tbl[i].r, tbl[i].pull, tbl[i].clear);
            cycle();
            chk($sformatf("v%0d_ready", i), 32'(out_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d_level", i), 32'(out_level), 32'(tbl[i].e_level));
            chk($sformatf("v%0d_fv", i), 32'(out_frame_valid), 32'(tbl[i].e_fv));
            chk($sformatf("v%0d_data", i), {out_left, out_right}, {tbl[i].e_l, tbl[i].e_r});
            chk($sformatf("v%0d_ur", i), 32'(out_underrun), 32'(tbl[i].e_ur));
        end

        // Fill to capacity, then a refused push alongside a pop
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 16'h3000 + 16'(i), 16'h4000 + 16'(i), 0, 0);
            q_l.push_back(16'h3000 + 16'(i));
            q_r.push_back(16'h4000 + 16'(i));
            cycle();
        end
        drive(0, 0, 16'h0, 16'h0, 0, 0);
        chk("full_ready", 32'(out_ready), 32'd0);
        chk("full_level", 32'(out_level), 32'd16);
        drive(0, 1, 16'h3FFF, 16'h4FFF, 1, 0);
        cycle();
        el = q_l.pop_front(); er = q_r.pop_front();
        chk("full_pushpull_data", {out_left, out_right}, {el, er});
        chk("full_pushpull_level", 32'(out_level), 32'd15);
        chk("full_pushpull_ready", 32'(out_ready), 32'd1);

        // Streaming across pointer wrap
        for (int k = 0; k < 40; k++) begin
            drive(0, 1, 16'h5000 + 16'(k), 16'h6000 + 16'(k), 1, 0);
            q_l.push_back(16'h5000 + 16'(k));
            q_r.push_back(16'h6000 + 16'(k));
            cycle();
            el = q_l.pop_front(); er = q_r.pop_front();
            chk($sformatf("wrap%0d_data", k), {out_left, out_right}, {el, er});
            chk($sformatf("wrap%0d_level", k), 32'(out_level), 32'd15);
        end

        // Drain to 10, then reset mid-operation
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 16'h0, 16'h0, 1, 0);
            cycle();
            el = q_l.pop_front(); er = q_r.pop_front();
            chk($sformatf("drain%0d_data", k), {out_left, out_right}, {el, er});
        end
        chk("drain_level", 32'(out_level), 32'd10);
        drive(1, 0, 16'h0, 16'h0, 1, 0);
        cycle();
        chk("rst_level", 32'(out_level), 32'd0);
        chk("rst_ready", 32'(out_ready), 32'd0);
        chk("rst_fv", 32'(out_frame_valid), 32'd0);
        chk("rst_data", {out_left, out_right}, 32'h0);
        chk("rst_ur", 32'(out_underrun), 32'd0);
        drive(0, 0, 16'h0, 16'h0, 0, 0);
        cycle();
        chk("postrst_ready", 32'(out_ready), 32'd1);
        drive(0, 0, 16'h0, 16'h0, 1, 0);
        cycle();
        chk("postrst_pull_fv", 32'(out_frame_valid), 32'd1);
        chk("postrst_pull_data", {out_left, out_right}, 32'h0);
        chk("postrst_pull_level", 32'(out_level), 32'd0);
        chk("postrst_pull_ur", 32'(out_underrun), 32'd0);

        // Prime, drain, then a pull at level 0 with a simultaneous push
        drive(0, 1, 16'h1111, 16'h2222, 0, 0); cycle();
        drive(0, 1, 16'h3333, 16'h4444, 0, 0); cycle();
        drive(0, 1, 16'h5555, 16'h6666, 0, 0); cycle();
        drive(0, 1, 16'h1234, 16'h5678, 0, 0); cycle();
        drive(0, 0, 16'h0, 16'h0, 0, 0); cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 16'h0, 16'h0, 1, 0);
            cycle();
        end
        chk("drain4_data", {out_left, out_right}, 32'h12345678);
        chk("drain4_level", 32'(out_level), 32'd0);
        drive(0, 1, 16'h7777, 16'h7878, 1, 0);
        cycle();
        chk("ur_push_fv", 32'(out_frame_valid), 32'd1);
        chk("ur_push_data", {out_left, out_right}, {hc_l, hc_r});
        chk("ur_push_ur", 32'(out_underrun), 32'd1);
        chk("ur_push_level", 32'(out_level), 32'd1);
        drive(0, 0, 16'h0, 16'h0, 1, 0);
        cycle();
        chk("fill_pull_data", {out_left, out_right}, {hc_l, hc_r});
        chk("fill_pull_level", 32'(out_level), 32'd1);
        chk("fill_pull_ur", 32'(out_underrun), 32'd1);
        drive(0, 0, 16'h0, 16'h0, 0, 0);
        cycle();
        chk("idle_fv", 32'(out_frame_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_audio_sample_buffer
`default_nettype wire
